// File: rtl/mxv_pkg.sv
// mxv_pkg: shared types, default sizes and the result saturation helper for
// the sequenced matrix-vector engine. sat_to_dw is only used in builds that
// define MXV_SAT_EN.
package mxv_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOAD_VEC = 3'd1,
      S_LOAD_MAT = 3'd2,
      S_COMPUTE  = 3'd3,
      S_DRAIN    = 3'd4
   } mxv_state_e;

   localparam int MXV_VEC_LEN = 3;
   localparam int MXV_OUT_LEN = 5;
   localparam int MXV_DW      = 32;

   // Clamp a sign-extended wide sum into the signed range of a dw-bit result.
   // The clamped value is returned in the low dw bits of a 64-bit word.
   function automatic logic [63:0] sat_to_dw(input logic signed [127:0] v,
                                             input int dw);
      logic signed [127:0] hi;
      logic signed [127:0] lo;
      hi = (128'sd1 <<< (dw - 1)) - 128'sd1;
      lo = -hi - 128'sd1;
      if (v > hi) begin
         return hi[63:0];
      end else if (v < lo) begin
         return lo[63:0];
      end else begin
         return v[63:0];
      end
   endfunction

endpackage

// File: rtl/mxv_mac.sv
// mxv_mac: signed multiply-accumulate with a full-width product. acc_next is
// the value the accumulator takes on this edge; clr makes the current term
// the first of a fresh sum so the caller can register the final total on the
// same edge that performs the last MAC.
module mxv_mac #(
   parameter int DW    = 32,
   parameter int ACC_W = 66
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic                    en,
   input  logic signed [DW-1:0]    a,
   input  logic signed [DW-1:0]    b,
   output logic signed [ACC_W-1:0] acc_next
);

   logic signed [2*DW-1:0]  prod;
   logic signed [ACC_W-1:0] acc;

   assign prod     = (2*DW)'(a) * (2*DW)'(b);
   assign acc_next = (clr ? '0 : acc) + ACC_W'(prod);

   // Accumulator register: advances only while the engine is computing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc_next;
      end
   end

endmodule

// File: rtl/mxv_seq.sv
// mxv_seq: sequenced matrix-vector engine. Loads a vector then a matrix
// (j fastest) over one valid/ready stream, computes each result[j] with one
// MAC per cycle and streams results out over a valid/ready port.
// Build option: define MXV_SAT_EN to saturate results to the DW-bit signed
// range; otherwise results wrap to the low DW bits of the sum.
module mxv_seq
   import mxv_pkg::*;
#(
   parameter int  VEC_LEN = MXV_VEC_LEN,
   parameter int  OUT_LEN = MXV_OUT_LEN,
   parameter int  DW      = MXV_DW,
   localparam int IDX_W   = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DW-1:0]    out_data,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_last,
   output logic             busy,
   output logic             done
);

   localparam int MAT_N = VEC_LEN * OUT_LEN;
   localparam int I_W   = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
   localparam int CNT_W = (MAT_N > 1) ? $clog2(MAT_N) : 1;
   localparam int ACC_W = 2*DW + $clog2(VEC_LEN);

   mxv_state_e        state;
   logic [CNT_W-1:0]  load_cnt;
   logic [I_W-1:0]    i_cnt;
   logic [IDX_W-1:0]  j_cnt;
   logic [DW-1:0]     vec_mem [VEC_LEN];
   logic [DW-1:0]     mat_mem [MAT_N];
   logic [CNT_W-1:0]  mat_rd_idx;
   logic signed [ACC_W-1:0] mac_sum;
   logic [DW-1:0]     result_w;

   // Matrix storage is row-major in i, so element [i][j] sits at i*OUT_LEN+j.
   assign mat_rd_idx = CNT_W'(i_cnt) * CNT_W'(OUT_LEN) + CNT_W'(j_cnt);

   mxv_mac #(
      .DW    (DW),
      .ACC_W (ACC_W)
   ) u_mac (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (i_cnt == '0),
      .en       (state == S_COMPUTE),
      .a        ($signed(vec_mem[i_cnt])),
      .b        ($signed(mat_mem[mat_rd_idx])),
      .acc_next (mac_sum)
   );

`ifdef MXV_SAT_EN
   logic [63:0] sat_full;
   assign sat_full = sat_to_dw(128'(mac_sum), DW);
   assign result_w = DW'(sat_full);
`else
   assign result_w = DW'(mac_sum);
`endif

   // Control FSM with registered handshake/status outputs and operand buffers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         load_cnt  <= '0;
         i_cnt     <= '0;
         j_cnt     <= '0;
         vec_mem   <= '{default: '0};
         mat_mem   <= '{default: '0};
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_LOAD_VEC;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
                  load_cnt <= '0;
               end
            end
            S_LOAD_VEC: begin
               if (in_valid) begin
                  vec_mem[load_cnt[I_W-1:0]] <= in_data;
                  if (load_cnt == CNT_W'(VEC_LEN - 1)) begin
                     load_cnt <= '0;
                     state    <= S_LOAD_MAT;
                  end else begin
                     load_cnt <= load_cnt + CNT_W'(1);
                  end
               end
            end
            S_LOAD_MAT: begin
               if (in_valid) begin
                  mat_mem[load_cnt] <= in_data;
                  if (load_cnt == CNT_W'(MAT_N - 1)) begin
                     load_cnt <= '0;
                     in_ready <= 1'b0;
                     i_cnt    <= '0;
                     j_cnt    <= '0;
                     state    <= S_COMPUTE;
                  end else begin
                     load_cnt <= load_cnt + CNT_W'(1);
                  end
               end
            end
            S_COMPUTE: begin
               if (i_cnt == I_W'(VEC_LEN - 1)) begin
                  out_data  <= result_w;
                  out_idx   <= j_cnt;
                  out_valid <= 1'b1;
                  out_last  <= (j_cnt == IDX_W'(OUT_LEN - 1));
                  i_cnt     <= '0;
                  state     <= S_DRAIN;
               end else begin
                  i_cnt <= i_cnt + I_W'(1);
               end
            end
            S_DRAIN: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  if (j_cnt == IDX_W'(OUT_LEN - 1)) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= S_IDLE;
                  end else begin
                     j_cnt <= j_cnt + IDX_W'(1);
                     state <= S_COMPUTE;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mxv_seq.sv
// tb_mxv_seq: directed and randomized runs of mxv_seq checked against an
// arithmetic reference model (wide signed dot products per output column).
module tb_mxv_seq;

   localparam int VL = 3;
   localparam int OL = 5;
   localparam int DW = 32;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [IW-1:0] out_idx;
   logic          out_last;
   logic          busy;
   logic          done;

   int checks   = 0;
   int failures = 0;

   logic [31:0] vec_q [VL];
   logic [31:0] mat_q [VL][OL];

   always #5 clk = ~clk;

   mxv_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   // Reference: exact signed dot product, then wrap or saturate to 32 bits.
   function automatic logic [31:0] model(input int j);
      logic signed [127:0] s;
      s = 128'sd0;
      for (int i = 0; i < VL; i++) begin
         s += 128'($signed(vec_q[i])) * 128'($signed(mat_q[i][j]));
      end
`ifdef MXV_SAT_EN
      if (s > 128'sd2147483647) return 32'h7FFF_FFFF;
      if (s < -128'sd2147483648) return 32'h8000_0000;
`endif
      return s[31:0];
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic set_basic();
      for (int i = 0; i < VL; i++) begin
         vec_q[i] = 32'(i + 1);
         for (int j = 0; j < OL; j++) mat_q[i][j] = 32'(i*OL + j + 1);
      end
   endtask

   task automatic push(input logic [31:0] v, input bit glitch);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = v;
      start    = glitch;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("in_ready_wait", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", busy, 1);
      check("in_ready_load", in_ready, 1);
   endtask

   task automatic run_job(input int hold0, input bit rnd, input int glitch_at);
      logic [31:0] exp_v;
      int lat;
      int hold;
      pulse_start();
      for (int i = 0; i < VL; i++) push(vec_q[i], 1'b0);
      for (int k = 0; k < VL*OL; k++) push(mat_q[k/OL][k%OL], k == glitch_at);
      check("in_ready_compute", in_ready, 0);
      for (int j = 0; j < OL; j++) begin
         exp_v = model(j);
         hold = (j == 0) ? hold0 : (rnd ? int'($urandom_range(0, 3)) : 0);
         out_ready = (hold == 0);
         lat = 0;
         while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
         end
         check("latency", 64'(lat), 64'(VL));
         check("out_data", out_data, exp_v);
         check("out_idx", out_idx, 64'(j));
         check("out_last", out_last, 64'(j == OL-1));
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_data", out_data, exp_v);
            check("hold_idx", out_idx, 64'(j));
            check("hold_valid", out_valid, 1);
            check("hold_busy", busy, 1);
         end
         out_ready = 1'b1;
         @(negedge clk);
         check("valid_drop", out_valid, 0);
         if (j < OL-1) check("done_early", done, 0);
      end
      check("done_pulse", done, 1);
      check("busy_end", busy, 0);
      @(negedge clk);
      check("done_clear", done, 0);
      check("idle_after_run", busy, 0);
      $display("run complete hold0=%0d rnd=%0d glitch_at=%0d checks=%0d", hold0, rnd, glitch_at, checks);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {in_ready, out_valid, out_data, out_idx, out_last, busy, done}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // in_valid in IDLE is ignored
      in_valid = 1'b1;
      in_data  = 32'd99;
      repeat (3) begin
         @(negedge clk);
         check("idle_in_ready", in_ready, 0);
         check("idle_busy", busy, 0);
      end
      in_valid = 1'b0;

      // basic run: 46,52,58,64,70
      set_basic();
      run_job(0, 1'b0, -1);

      // backpressure on result 0
      set_basic();
      run_job(10, 1'b0, -1);

      // start pulsed during matrix load is ignored
      set_basic();
      run_job(0, 1'b0, 7);

      // overflow case
      vec_q[0] = 32'h4000_0000;
      vec_q[1] = 32'h4000_0000;
      vec_q[2] = 32'h0;
      for (int j = 0; j < OL; j++) begin
         mat_q[0][j] = 32'd2;
         mat_q[1][j] = 32'd2;
         mat_q[2][j] = 32'd0;
      end
      run_job(0, 1'b0, -1);

      // reset after 7 matrix accepts, then a fresh full run
      set_basic();
      pulse_start();
      for (int i = 0; i < VL; i++) push(vec_q[i], 1'b0);
      for (int k = 0; k < 7; k++) push(mat_q[k/OL][k%OL], 1'b0);
      rst_n = 1'b0;
      #1;
      check("midrun_reset_outputs", {in_ready, out_valid, out_data, out_idx, out_last, busy, done}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_job(0, 1'b0, -1);

      // randomized operands and backpressure
      repeat (4) begin
         for (int i = 0; i < VL; i++) begin
            vec_q[i] = $urandom();
            for (int j = 0; j < OL; j++) mat_q[i][j] = $urandom();
         end
         run_job(int'($urandom_range(0, 4)), 1'b1, int'($urandom_range(0, VL*OL-1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mxv_seq.md
Name: mxv_seq

Overview:
Sequenced, area-reduced matrix-vector engine built around one time-shared multiply-accumulate unit.
- Loads a VEC_LEN-element vector and a VEC_LEN x OUT_LEN matrix over a single valid/ready input stream.
- Computes result[j] = sum over i of matrix[i][j]*vector[i], one MAC per cycle.
- Streams the OUT_LEN results out over a valid/ready port.
- Used where the fully parallel combinational multiply is too large or too slow for the clock.

Parameters:
- VEC_LEN, 3, vector length (matrix first dimension, index i); must be >=1.
- OUT_LEN, 5, result length (matrix second dimension, index j); must be >=1.
- DW, 32, signed data width of inputs and results.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- in_valid  in  1  input element valid.
- in_ready  out  1  input element accepted when in_valid & in_ready.
- in_data  in  DW  signed element.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  DW  signed result[j].
- out_idx  out  $clog2(OUT_LEN) (min 1)  index j of out_data.
- out_last  out  1  high with out_valid when j == OUT_LEN-1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on the edge after the final result handshake.

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0; counters, accumulator and buffers cleared. Reset mid-operation abandons the run; the next start begins a fresh load.
- States: IDLE, LOAD_VEC, LOAD_MAT, COMPUTE, DRAIN.
- IDLE:
  - in_ready=0.
  - start moves to LOAD_VEC.
  - in_valid is ignored and nothing is consumed.
- LOAD_VEC:
  - in_ready=1.
  - Accepts VEC_LEN elements into vector[0..VEC_LEN-1] in order.
  - On the last accept, moves to LOAD_MAT.
- LOAD_MAT:
  - in_ready=1.
  - Accepts VEC_LEN*OUT_LEN elements in order matrix[0][0..OUT_LEN-1], matrix[1][...], and so on (j fastest).
  - On the last accept, j=0 and the state moves to COMPUTE.
- COMPUTE:
  - in_ready=0.
  - Accumulator cleared on entry, then one MAC per cycle for i=0..VEC_LEN-1.
  - On the i=VEC_LEN-1 edge, the final sum is registered into out_data, out_idx=j, out_valid=1, out_last=(j==OUT_LEN-1), and the state moves to DRAIN.
  - out_valid therefore rises exactly VEC_LEN edges after entering COMPUTE.
- DRAIN:
  - out_data, out_idx and out_last are held stable while out_valid & !out_ready.
  - On handshake, out_valid=0.
  - If j==OUT_LEN-1: go to IDLE and pulse done for one cycle.
  - Otherwise: j++ and go to COMPUTE.
- Arithmetic:
  - Products are computed at full 2*DW signed width.
  - The accumulator is 2*DW+$clog2(VEC_LEN) wide.
  - Default result = low DW bits of the sum (two's-complement wrap, bit-identical to DW-bit modular arithmetic).
- start while busy is ignored; no restart and no queuing.
- out_ready asserted while out_valid=0 has no effect.
- Results and stored operands are not retained across runs; every run reloads the vector and matrix.

Optional Feature:
- Macro: MXV_SAT_EN.
- Defined: the final sum is saturated to [-2^(DW-1), 2^(DW-1)-1] before registering into out_data.
- Undefined: low-DW-bit wrap as above.
- Latency and handshakes are identical either way.

Decomposition:
- Package mxv_pkg holds:
  - state enum type mxv_state_e;
  - default constants MXV_VEC_LEN=3, MXV_OUT_LEN=5, MXV_DW=32;
  - function sat_to_dw, used only under MXV_SAT_EN.
- One sub-module, mxv_mac: signed multiply-accumulate with clr/en inputs and a wide accumulator output. Result narrowing (wrap or MXV_SAT_EN saturation) is done in mxv_seq.

Test Plan:
- Basic run: vector [1,2,3]; matrix rows 1..5, 6..10, 11..15; out_ready=1 -> results 46,52,58,64,70 with out_idx 0..4, out_last only on 70, done pulse after the 70 handshake.
- Latency: same run -> out_valid rises 3 edges after the final matrix accept; each subsequent result rises 3 edges after the prior handshake.
- Backpressure: hold out_ready=0 for 10 cycles on result 0 -> out_data=46 and out_idx=0 held stable, result 1 never computed early, busy stays 1.
- Overflow: vector [0x40000000,0x40000000,0]; matrix rows 0 and 1 all 2, row 2 all 0 -> without MXV_SAT_EN all results 0x00000000; with MXV_SAT_EN all results 0x7FFFFFFF.
- Protocol guards: in_valid=1 in IDLE -> in_ready=0, nothing consumed; start pulsed during LOAD_MAT -> ignored, run completes with correct results.
- Reset mid-operation: rst_n low after 7 matrix accepts -> all outputs 0 immediately; next start plus a full reload yields 46,52,58,64,70.
